// File: rtl/rgbw_pwm_engine.sv
// rgbw_pwm_engine
//   Four-channel (R/G/B/W) PWM engine with double-buffered duty registers.
//   Duty values are captured into shadow registers by a load strobe and
//   become active only at a period boundary (counter wrap), or immediately
//   while the engine is disabled. Each PWM output is registered and reflects
//   the comparison (cnt < active) made on the previous tick edge.
//
// Parameters
//   PERIOD_MAX    last counter value; one period is PERIOD_MAX+1 ticks
//
// Ports
//   clk           system clock, rising-edge active
//   reset         asynchronous active-low reset
//   tick          prescaler enable; counter and outputs advance only when 1
//   en            engine enable; 0 forces outputs low and the counter to 0
//   load          single-cycle strobe capturing duty_* into the shadow regs
//   duty_r/g/b/w  requested 8-bit duty values
//   pending       shadow holds values not yet applied
//   upd_ack       one-cycle pulse after shadow values become active
//   period_start  one-cycle pulse after each counter wrap to 0
//   d_r/g/b/w     registered PWM drive outputs
module rgbw_pwm_engine #(
  parameter int unsigned PERIOD_MAX = 254
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] duty_r,
  input  logic [7:0] duty_g,
  input  logic [7:0] duty_b,
  input  logic [7:0] duty_w,
  output logic       pending,
  output logic       upd_ack,
  output logic       period_start,
  output logic       d_r,
  output logic       d_g,
  output logic       d_b,
  output logic       d_w
);

  localparam logic [7:0] CNT_LAST = 8'(PERIOD_MAX);

  logic [7:0]      cnt;
  logic [3:0][7:0] shadow;
  logic [3:0][7:0] active;
  logic [3:0][7:0] duty_in;
  logic [3:0]      drive;
  logic [3:0]      hit;
  logic            advance;
  logic            wrap;
  logic            xfer;

  assign duty_in = {duty_w, duty_b, duty_g, duty_r};
  assign {d_w, d_b, d_g, d_r} = drive;

  always_comb begin
    advance = en & tick;
    wrap    = advance & (cnt == CNT_LAST);
    // Shadow moves to active at a period boundary, or at once while disabled
    // since no period is running to protect.
    xfer    = pending & (wrap | ~en);
    for (int unsigned i = 0; i < 4; i++) begin
      hit[i] = (cnt < active[i]);
    end
  end

  // Period counter and registered PWM outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      drive        <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (!en) begin
        cnt   <= '0;
        drive <= '0;
      end else if (tick) begin
        // Compare uses the pre-increment count and the pre-transfer active
        // values, so a transfer on the wrap edge affects the next period only.
        drive <= hit;
        cnt   <= wrap ? '0 : cnt + 8'd1;
      end
    end
  end

  // Shadow/active double buffer. A load coinciding with a transfer moves the
  // old shadow to active while capturing the new values, leaving pending set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      upd_ack <= 1'b0;
    end else begin
      upd_ack <= xfer;
      if (xfer) begin
        active <= shadow;
      end
      if (load) begin
        shadow  <= duty_in;
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
